question_box_controller: RTL and testbench
==========================================

Name: question_box_controller

Overview:
- Sequential companion to the question-box renderer. It drives the renderer's box_x/box_y inputs and owns the box's game behaviour.
- On a player hit, the box plays a frame-paced bounce (moves up, then back down).
- After the bounce it produces a dice result (1..6) from a free-running LFSR and offers it to game logic over a valid/ready handshake.
- It then holds the box "used" for a cooldown period before re-arming.
- Sits between game logic and the UI render mux; runs in the pixel clock domain.

Parameters:
- BOUNCE_HEIGHT, 4, peak upward displacement in pixels (1..15).
- FRAMES_PER_STEP, 2, frame_tick pulses per 1-pixel bounce step (>=1).
- COOLDOWN_FRAMES, 30, frame_tick pulses spent in COOLDOWN (0 allowed).
- LFSR_SEED, 8'hA5, LFSR reset value; a value of 0 is replaced by 8'h01.

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame (vsync-derived)
- hit  in  1  one-cycle request: player struck the box
- base_x  in  10  box rest-position centre x
- base_y  in  10  box rest-position centre y
- box_x  out  10  registered centre x to renderer
- box_y  out  10  registered centre y to renderer (includes bounce offset)
- used  out  1  high in RESULT and COOLDOWN (renderer may grey the box)
- busy  out  1  high whenever state != IDLE
- dice_valid  out  1  dice result available
- dice_value  out  3  result 1..6; stable while dice_valid=1
- dice_ready  in  1  consumer accepts the result

Behaviour:
- Reset values (async): state=IDLE, offset=0, step_cnt=0, cd_cnt=0, box_x=0, box_y=0, used=0, busy=0, dice_valid=0, dice_value=0, lfsr=LFSR_SEED (or 8'h01 if the seed is 0).
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every clk in every state; never reaches 0.
- Position outputs, updated every cycle (1-cycle latency from base_*/offset):
  - box_x <= base_x.
  - box_y <= base_y - offset; if base_y < offset, box_y <= 0 (no wrap).
- IDLE:
  - hit=1 -> RISE; step_cnt=0, offset=0.
  - A frame_tick in the same cycle as hit is not counted.
  - hit in any other state is ignored.
- RISE:
  - On each frame_tick, step_cnt++.
  - When step_cnt reaches FRAMES_PER_STEP-1 on a tick: step_cnt=0, offset++.
  - When offset becomes BOUNCE_HEIGHT -> FALL.
- FALL:
  - Same pacing as RISE; offset--.
  - When offset becomes 0 -> RESULT.
  - On that same transition: dice_valid<=1, dice_value <= (lfsr % 6) + 1, using the lfsr value present in that cycle.
- Bounce duration: exactly 2*BOUNCE_HEIGHT*FRAMES_PER_STEP frame_ticks (16 with defaults).
- RESULT:
  - dice_valid held high; dice_value frozen.
  - Transfer occurs on a cycle with dice_valid && dice_ready. Next cycle: dice_valid=0, state -> COOLDOWN, cd_cnt=0.
  - dice_ready while dice_valid=0 has no effect.
  - No timeout: RESULT waits indefinitely.
- COOLDOWN:
  - cd_cnt increments on each frame_tick.
  - When cd_cnt reaches COOLDOWN_FRAMES -> IDLE.
  - If COOLDOWN_FRAMES=0 -> IDLE on the next cycle.
- busy: high in RISE/FALL/RESULT/COOLDOWN. used: high in RESULT/COOLDOWN only.
- Changes to base_x/base_y mid-bounce are tracked immediately; offset is applied to the current base_y.
- Reset asserted mid-operation: immediate return to reset values. dice_valid drops asynchronously; a pending result is discarded.
- frame_tick wider than one cycle is out of spec (each high cycle counts).

Test Plan:
- Reset with base=(320,240) -> cycle after reset release: box=(320,240), busy=0, used=0, dice_valid=0.
- hit then 16 frame_ticks, defaults, base_y=240 -> box_y sequence per 2 ticks: 239,238,237,236,237,238,239,240. dice_valid rises on the tick that returns offset to 0. dice_value matches a model of (lfsr%6)+1 with seed 0xA5, cycle-exact.
- In RESULT, hold dice_ready=0 for 100 cycles -> dice_valid stays 1, dice_value constant. Pulse dice_ready -> exactly one transfer; used=1 stays through 30 ticks, then IDLE, used=0.
- hit pulses during RISE, FALL, RESULT, COOLDOWN -> no state change, no extra result. hit coincident with frame_tick in IDLE -> bounce still takes exactly 16 ticks.
- base_y=2 with BOUNCE_HEIGHT=4 -> box_y clamps 1,0,0,0 then returns 0,0,1,2; never wraps to ~1020.
- Assert reset mid-FALL and again in RESULT -> outputs return to reset values asynchronously. Next hit produces a fresh 16-tick bounce. COOLDOWN_FRAMES=0 build returns to IDLE one cycle after the transfer.

Source files
------------

// File: rtl/question_box_controller.sv
// Question-box controller: frame-paced bounce on hit, LFSR dice result over a
// valid/ready handshake, then a frame-counted cooldown before re-arming.
module question_box_controller #(
  parameter int unsigned BOUNCE_HEIGHT   = 4,
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic [9:0] base_x,
  input  logic [9:0] base_y,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       used,
  output logic       busy,
  output logic       dice_valid,
  output logic [2:0] dice_value,
  input  logic       dice_ready
);

  localparam int unsigned SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(FRAMES_PER_STEP - 1);
  localparam logic [CW-1:0] CD_LAST   = CW'(COOLDOWN_FRAMES);
  localparam logic [3:0]    PEAK      = 4'(BOUNCE_HEIGHT);
  // An all-zero seed would lock the LFSR, so it is substituted.
  localparam logic [7:0]    SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RISE,
    S_FALL,
    S_RESULT,
    S_COOLDOWN
  } state_t;

  state_t        r_state, w_state_n;
  logic [3:0]    r_offset, w_offset_n;
  logic [SW-1:0] r_step, w_step_n;
  logic [CW-1:0] r_cd, w_cd_n;
  logic          r_valid, w_valid_n;
  logic [2:0]    r_value, w_value_n;
  logic [7:0]    r_lfsr;
  logic          w_fb;
  logic [9:0]    r_box_x, r_box_y;
  logic [9:0]    w_box_y_n;

  assign w_fb      = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_box_y_n = (base_y < {6'd0, r_offset}) ? 10'd0 : (base_y - {6'd0, r_offset});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_offset <= '0;
      r_step   <= '0;
      r_cd     <= '0;
      r_valid  <= 1'b0;
      r_value  <= 3'd0;
      r_lfsr   <= SEED;
      r_box_x  <= 10'd0;
      r_box_y  <= 10'd0;
    end else begin
      r_state  <= w_state_n;
      r_offset <= w_offset_n;
      r_step   <= w_step_n;
      r_cd     <= w_cd_n;
      r_valid  <= w_valid_n;
      r_value  <= w_value_n;
      r_lfsr   <= {r_lfsr[6:0], w_fb};
      r_box_x  <= base_x;
      r_box_y  <= w_box_y_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_offset_n = r_offset;
    w_step_n   = r_step;
    w_cd_n     = r_cd;
    w_valid_n  = r_valid;
    w_value_n  = r_value;
    case (r_state)
      S_IDLE: begin
        if (hit) begin
          w_state_n  = S_RISE;
          w_step_n   = '0;
          w_offset_n = '0;
        end
      end
      S_RISE: begin
        if (frame_tick) begin
          if (r_step == STEP_LAST) begin
            w_step_n   = '0;
            w_offset_n = r_offset + 4'd1;
            if ((r_offset + 4'd1) == PEAK) w_state_n = S_FALL;
          end else begin
            w_step_n = r_step + SW'(1);
          end
        end
      end
      S_FALL: begin
        if (frame_tick) begin
          if (r_step == STEP_LAST) begin
            w_step_n   = '0;
            w_offset_n = r_offset - 4'd1;
            // Dice is sampled from the LFSR as it stands on the landing tick.
            if (r_offset == 4'd1) begin
              w_state_n = S_RESULT;
              w_valid_n = 1'b1;
              w_value_n = 3'(r_lfsr % 8'd6) + 3'd1;
            end
          end else begin
            w_step_n = r_step + SW'(1);
          end
        end
      end
      S_RESULT: begin
        if (r_valid && dice_ready) begin
          w_valid_n = 1'b0;
          w_state_n = S_COOLDOWN;
          w_cd_n    = '0;
        end
      end
      S_COOLDOWN: begin
        if (r_cd == CD_LAST) begin
          w_state_n = S_IDLE;
        end else if (frame_tick) begin
          w_cd_n = r_cd + CW'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign box_x      = r_box_x;
  assign box_y      = r_box_y;
  assign busy       = (r_state != S_IDLE);
  assign used       = (r_state == S_RESULT) || (r_state == S_COOLDOWN);
  assign dice_valid = r_valid;
  assign dice_value = r_value;

endmodule

// File: tb/tb_question_box_controller.sv
// Directed bench for question_box_controller: default build plus a
// zero-cooldown, single-step build sharing clock, reset and frame_tick.
module tb_question_box_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       hit;
  logic       dice_ready;
  logic [9:0] base_x;
  logic [9:0] base_y;
  logic [9:0] box_x, box_y;
  logic       used, busy, dice_valid;
  logic [2:0] dice_value;

  logic       hit0, ready0;
  logic [9:0] boxX0, boxY0;
  logic       used0, busy0, valid0;
  logic [2:0] value0;

  int errors = 0;
  int checks = 0;
  logic [7:0] lfsrModel;
  logic [7:0] lfsrPre;
  logic [2:0] expDice;

  always #5 clk = ~clk;

  question_box_controller u_dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .hit        (hit),
    .base_x     (base_x),
    .base_y     (base_y),
    .box_x      (box_x),
    .box_y      (box_y),
    .used       (used),
    .busy       (busy),
    .dice_valid (dice_valid),
    .dice_value (dice_value),
    .dice_ready (dice_ready)
  );

  question_box_controller #(
    .BOUNCE_HEIGHT   (1),
    .FRAMES_PER_STEP (1),
    .COOLDOWN_FRAMES (0)
  ) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .hit        (hit0),
    .base_x     (base_x),
    .base_y     (base_y),
    .box_x      (boxX0),
    .box_y      (boxY0),
    .used       (used0),
    .busy       (busy0),
    .dice_valid (valid0),
    .dice_value (value0),
    .dice_ready (ready0)
  );

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 0xA5, stepping every clock.
  function automatic logic [7:0] lfsrNext(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [2:0] diceOf(input logic [7:0] v);
    return 3'((v % 8'd6) + 8'd1);
  endfunction

  // Offset after t ticks for the default build (4 px, 2 ticks per px).
  function automatic int bounceOffset(input int t);
    if (t <= 8) return t / 2;
    return 4 - (t - 8) / 2;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) lfsrModel <= 8'hA5;
    else       lfsrModel <= lfsrNext(lfsrModel);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseTick();
    lfsrPre    = lfsrModel;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic pulseHit();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
  endtask

  task automatic finishCooldown();
    dice_ready = 1'b1;
    cyc();
    dice_ready = 1'b0;
    repeat (30) begin
      pulseTick();
      cyc();
    end
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0; hit = 1'b0; dice_ready = 1'b0;
    hit0 = 1'b0; ready0 = 1'b0; base_x = 10'd320; base_y = 10'd240;
    repeat (3) cyc();
    checks++;
    if (box_y !== 10'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold box_y=%0d busy=%b expected 0/0", box_y, busy);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (box_x !== 10'd320 || box_y !== 10'd240) begin
      errors++; $display("FAIL reset_pos box=(%0d,%0d) expected (320,240)", box_x, box_y);
    end
    checks++;
    if (busy !== 1'b0 || used !== 1'b0 || dice_valid !== 1'b0 || dice_value !== 3'd0) begin
      errors++; $display("FAIL reset_flags busy=%b used=%b valid=%b value=%0d expected 0", busy, used, dice_valid, dice_value);
    end
  endtask

  task automatic test_bounce();
    pulseHit();
    checks++;
    if (busy !== 1'b1 || used !== 1'b0 || dice_valid !== 1'b0) begin
      errors++; $display("FAIL bounce_start busy=%b used=%b valid=%b expected 1/0/0", busy, used, dice_valid);
    end
    for (int t = 1; t <= 16; t++) begin
      pulseTick();
      checks++;
      if (dice_valid !== (t == 16)) begin
        errors++; $display("FAIL bounce_valid tick=%0d valid=%b expected %b", t, dice_valid, (t == 16));
      end
      cyc();
      if (t % 2 == 0) begin
        checks++;
        if (box_y !== 10'(240 - bounceOffset(t))) begin
          errors++; $display("FAIL bounce_y tick=%0d box_y=%0d expected %0d", t, box_y, 240 - bounceOffset(t));
        end
      end
    end
    expDice = diceOf(lfsrPre);
    checks++;
    if (dice_value !== expDice || used !== 1'b1) begin
      errors++; $display("FAIL bounce_dice value=%0d used=%b expected %0d/1", dice_value, used, expDice);
    end
  endtask

  task automatic test_result_hold();
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      hit = (i == 50);
      cyc();
      if (dice_valid !== 1'b1 || dice_value !== expDice) bad++;
    end
    hit = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL result_hold bad_cycles=%0d expected 0 (value=%0d want %0d)", bad, dice_value, expDice);
    end
    dice_ready = 1'b1;
    cyc();
    dice_ready = 1'b0;
    checks++;
    if (dice_valid !== 1'b0 || used !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL transfer valid=%b used=%b busy=%b expected 0/1/1", dice_valid, used, busy);
    end
    repeat (5) cyc();
    checks++;
    if (dice_valid !== 1'b0) begin
      errors++; $display("FAIL single_transfer valid=%b expected 0", dice_valid);
    end
  endtask

  task automatic test_cooldown();
    for (int k = 1; k <= 30; k++) begin
      pulseTick();
      if (k == 5) pulseHit();
      cyc();
      if (k == 29) begin
        checks++;
        if (used !== 1'b1 || busy !== 1'b1 || dice_valid !== 1'b0) begin
          errors++; $display("FAIL cooldown_mid used=%b busy=%b valid=%b expected 1/1/0", used, busy, dice_valid);
        end
      end
    end
    checks++;
    if (used !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL cooldown_end used=%b busy=%b expected 0/0", used, busy);
    end
  endtask

  task automatic test_hit_ignored();
    hit = 1'b1; frame_tick = 1'b1;
    cyc();
    hit = 1'b0; frame_tick = 1'b0;
    for (int t = 1; t <= 16; t++) begin
      pulseTick();
      checks++;
      if (dice_valid !== (t == 16)) begin
        errors++; $display("FAIL coincident_valid tick=%0d valid=%b expected %b", t, dice_valid, (t == 16));
      end
      if (t == 3 || t == 11) pulseHit();
      cyc();
      if (t == 4 || t == 12) begin
        checks++;
        if (box_y !== 10'(240 - bounceOffset(t))) begin
          errors++; $display("FAIL ignored_hit_y tick=%0d box_y=%0d expected %0d", t, box_y, 240 - bounceOffset(t));
        end
      end
    end
    checks++;
    if (dice_value !== diceOf(lfsrPre)) begin
      errors++; $display("FAIL coincident_dice value=%0d expected %0d", dice_value, diceOf(lfsrPre));
    end
    finishCooldown();
  endtask

  task automatic test_clamp();
    int off;
    base_y = 10'd2;
    pulseHit();
    for (int t = 1; t <= 16; t++) begin
      pulseTick();
      if (t == 6) base_x = 10'd100;
      cyc();
      if (t % 2 == 0) begin
        off = bounceOffset(t);
        checks++;
        if (box_y !== ((off < 2) ? 10'(2 - off) : 10'd0)) begin
          errors++; $display("FAIL clamp_y tick=%0d box_y=%0d expected %0d", t, box_y, (off < 2) ? 2 - off : 0);
        end
      end
      if (t == 8) begin
        checks++;
        if (box_x !== 10'd100) begin
          errors++; $display("FAIL track_x box_x=%0d expected 100", box_x);
        end
      end
    end
    finishCooldown();
    base_x = 10'd320; base_y = 10'd240;
    cyc();
  endtask

  task automatic test_reset_mid();
    pulseHit();
    repeat (10) begin pulseTick(); cyc(); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || box_x !== 10'd0 || box_y !== 10'd0) begin
      errors++; $display("FAIL reset_fall busy=%b box=(%0d,%0d) expected 0/(0,0)", busy, box_x, box_y);
    end
    cyc();
    reset = 1'b0;
    cyc();
    pulseHit();
    repeat (16) begin pulseTick(); cyc(); end
    checks++;
    if (dice_valid !== 1'b1) begin
      errors++; $display("FAIL reach_result valid=%b expected 1", dice_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dice_valid !== 1'b0 || used !== 1'b0 || dice_value !== 3'd0) begin
      errors++; $display("FAIL reset_result valid=%b used=%b value=%0d expected 0/0/0", dice_valid, used, dice_value);
    end
    cyc();
    reset = 1'b0;
    cyc();
    checks++;
    if (box_x !== 10'd320 || box_y !== 10'd240 || dice_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset box=(%0d,%0d) valid=%b expected (320,240)/0", box_x, box_y, dice_valid);
    end
    pulseHit();
    for (int t = 1; t <= 16; t++) begin
      pulseTick();
      if (t >= 15) begin
        checks++;
        if (dice_valid !== (t == 16)) begin
          errors++; $display("FAIL fresh_valid tick=%0d valid=%b expected %b", t, dice_valid, (t == 16));
        end
      end
      cyc();
    end
    checks++;
    if (dice_value !== diceOf(lfsrPre)) begin
      errors++; $display("FAIL fresh_dice value=%0d expected %0d", dice_value, diceOf(lfsrPre));
    end
    finishCooldown();
  endtask

  task automatic test_cooldown_zero();
    hit0 = 1'b1;
    cyc();
    hit0 = 1'b0;
    pulseTick();
    checks++;
    if (busy0 !== 1'b1 || valid0 !== 1'b0) begin
      errors++; $display("FAIL zero_rise busy=%b valid=%b expected 1/0", busy0, valid0);
    end
    cyc();
    pulseTick();
    checks++;
    if (valid0 !== 1'b1 || used0 !== 1'b1 || value0 !== diceOf(lfsrPre)) begin
      errors++; $display("FAIL zero_result valid=%b used=%b value=%0d expected 1/1/%0d", valid0, used0, value0, diceOf(lfsrPre));
    end
    ready0 = 1'b1;
    cyc();
    ready0 = 1'b0;
    checks++;
    if (valid0 !== 1'b0 || used0 !== 1'b1) begin
      errors++; $display("FAIL zero_transfer valid=%b used=%b expected 0/1", valid0, used0);
    end
    cyc();
    checks++;
    if (busy0 !== 1'b0 || used0 !== 1'b0) begin
      errors++; $display("FAIL zero_idle busy=%b used=%b expected 0/0", busy0, used0);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_result_hold();
    test_cooldown();
    test_hit_ignored();
    test_clamp();
    test_reset_mid();
    test_cooldown_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
